tanh_output_layer: RTL
======================

Name: tanh_output_layer

Overview:
- Downstream stage of the hidden tanh layer in the LSTM/tanh network datapath.
- Consumes the hidden layer's NIN signed Q3.4 activations once its ack__layer is asserted.
- Computes NOUT neurons sequentially on one shared multiply-accumulate unit: y[j] = hardtanh(sum_i((w[j][i]*x[i]) >>> FRAC) + b[j]).
- Returns all outputs together under a req/ack handshake.

Parameters:
- NIN, 2, number of inputs per neuron (hidden-layer width), >=1.
- NOUT, 2, number of output neurons, >=1.
- FRAC, 4, fractional bits of the Q format (Q3.4 when 8-bit).
- ACCW, 16, accumulator width in bits, signed.
- WEIGHTS, {8'sd8, 8'sd16, 8'sd23, -8'sd23}, NOUT*NIN signed 8-bit weights; element (j,i) at bits [(j*NIN+i)*8 +: 8].
- BIASES, {8'sd4, -8'sd9}, NOUT signed 8-bit biases; element j at bits [j*8 +: 8].

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  1  start request, level; driven by the hidden layer's ack__layer.
- x  input  NIN*8  signed activations; x[i] at bits [i*8 +: 8]; sampled only at start.
- busy  output  1  high in MAC, BIAS and ACT states.
- ack  output  1  result-valid / handshake acknowledge.
- y  output  NOUT*8  signed results; y[j] at bits [j*8 +: 8].

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- rst low clears immediately, regardless of clk:
  - State goes to IDLE.
  - ack=0, busy=0, y=0.
  - Accumulator, i and j counters, and the input register are all 0.
- Reset mid-operation aborts the computation. No partial results are retained.
- States are IDLE, MAC, BIAS, ACT, DONE.
- IDLE: on an edge with req=1, register all of x, set i=0, j=0, acc=0, and go to MAC.
- MAC:
  - Each edge: acc <= acc + sext((w[j][i]*xr[i]) >>> FRAC).
  - The product is a full 16-bit signed value. The shift is arithmetic, so results floor toward -inf.
  - Each edge also does i++. When i==NIN-1, go to BIAS.
- BIAS: acc <= acc + sext(b[j]). The bias is already Q-format and is not shifted. Go to ACT.
- ACT:
  - y[j] <= clamp(acc, -(1<<FRAC), +(1<<FRAC)), i.e. ±16 at defaults (hard tanh).
  - Then acc=0, i=0.
  - If j==NOUT-1: go to DONE and set ack=1. Otherwise j++ and go to MAC.
- DONE:
  - ack stays 1 and y stays stable until req is sampled 0.
  - On that edge ack <= 0 and the state goes to IDLE.
  - If req is already 0 on entering DONE, ack is high for exactly one cycle.
- Latency: ack rises NOUT*(NIN+2) edges after the edge that sampled req in IDLE. That is 8 edges at the defaults.
- Re-arm:
  - A new start needs req=1 in IDLE.
  - A req held high continuously does not restart until it has been sampled low in DONE.
- req and x changes during MAC, BIAS or ACT are ignored. The computation always completes on the registered inputs.
- y updates per neuron during ACT. y is only guaranteed consistent while ack=1.
- Accumulator overflow beyond ACCW is not handled. NIN*2^(16-FRAC) must fit in ACCW, and this is checked by an elaboration assertion.

Test Plan:
1. Reset: assert rst=0 asynchronously mid-MAC (between edges) -> ack=0, busy=0, y=0 immediately; after release, IDLE.
2. Zero inputs: x0=0, x1=0, req=1 -> ack at edge 8; y0=-9, y1=4; busy high for edges 1..8 window.
3. Linear range: x0=3, x1=5 -> y0 = (-5)+7-9 = -7, y1 = 3+2+4 = 9.
4. Floor rounding: x0=1, x1=0 -> y0 = -2-9 = -11 (floor of -1.4375), y1 = 1+4 = 5.
5. Saturation: x0=16, x1=8 -> n0 sum -21 gives y0=-16; n1 sum 24 gives y1=16.
6. Handshake:
   - req held high for 5 cycles after ack -> ack and y stable, no restart.
   - req dropped -> ack falls next edge.
   - req pulsed 1 cycle only -> ack high exactly 1 cycle.
   - Changing x mid-compute does not alter the results.

Source files
------------

// File: rtl/tanh_output_layer.sv
// Output layer of the tanh network: NOUT neurons computed on one shared MAC,
// each result clamped to +/-1.0 (hard tanh), all returned under a req/ack handshake.
module tanh_output_layer #(
   parameter int NIN  = 2,
   parameter int NOUT = 2,
   parameter int FRAC = 4,
   parameter int ACCW = 16,
   parameter logic [NOUT*NIN*8-1:0] WEIGHTS = {8'sd8, 8'sd16, 8'sd23, -8'sd23},
   parameter logic [NOUT*8-1:0]     BIASES  = {8'sd4, -8'sd9}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [NIN*8-1:0]  x,
   output logic              busy,
   output logic              ack,
   output logic [NOUT*8-1:0] y
);

   localparam int IW = (NIN  > 1) ? $clog2(NIN)  : 1;
   localparam int JW = (NOUT > 1) ? $clog2(NOUT) : 1;
   localparam logic signed [ACCW-1:0] POS_LIM = ACCW'(1 << FRAC);
   localparam logic signed [ACCW-1:0] NEG_LIM = -POS_LIM;
   localparam longint NEED = longint'(NIN) * (longint'(1) << (16 - FRAC));
   localparam longint CAP  = (longint'(1) << (ACCW - 1)) - longint'(1);

   // Worst-case sum of shifted products must not overflow the accumulator.
   if (NEED > CAP) begin : g_accw_check
      $error("tanh_output_layer: ACCW too small for NIN and FRAC");
   end

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MAC  = 3'd1,
      S_BIAS = 3'd2,
      S_ACT  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t                 state_r;
   logic [NIN*8-1:0]       xr_r;
   logic [IW-1:0]          i_r;
   logic [JW-1:0]          j_r;
   logic signed [ACCW-1:0] acc_r;

   logic signed [7:0]      w_sel_s;
   logic signed [7:0]      x_sel_s;
   logic signed [15:0]     prod_s;
   logic signed [ACCW-1:0] term_s;
   logic signed [ACCW-1:0] bias_s;
   logic signed [7:0]      act_s;

   // Operand selection, floor-shifted product, bias extension and hard-tanh clamp.
   always_comb begin
      w_sel_s = $signed(WEIGHTS[(int'(j_r) * NIN + int'(i_r)) * 8 +: 8]);
      x_sel_s = $signed(xr_r[int'(i_r) * 8 +: 8]);
      prod_s  = w_sel_s * x_sel_s;
      term_s  = ACCW'(prod_s >>> FRAC);
      bias_s  = ACCW'($signed(BIASES[int'(j_r) * 8 +: 8]));
      if (acc_r > POS_LIM) begin
         act_s = POS_LIM[7:0];
      end else if (acc_r < NEG_LIM) begin
         act_s = NEG_LIM[7:0];
      end else begin
         act_s = acc_r[7:0];
      end
   end

   // Sequencer: one MAC term per edge, then bias, then activation per neuron.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= S_IDLE;
         xr_r    <= '0;
         i_r     <= '0;
         j_r     <= '0;
         acc_r   <= '0;
         busy    <= 1'b0;
         ack     <= 1'b0;
         y       <= '0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (req) begin
                  xr_r    <= x;
                  i_r     <= '0;
                  j_r     <= '0;
                  acc_r   <= '0;
                  busy    <= 1'b1;
                  state_r <= S_MAC;
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_MAC: begin
               acc_r <= acc_r + term_s;
               if (i_r == IW'(NIN - 1)) begin
                  state_r <= S_BIAS;
               end else begin
                  i_r <= i_r + IW'(1);
               end
            end
            S_BIAS: begin
               acc_r   <= acc_r + bias_s;
               state_r <= S_ACT;
            end
            S_ACT: begin
               y[int'(j_r) * 8 +: 8] <= act_s;
               acc_r <= '0;
               i_r   <= '0;
               if (j_r == JW'(NOUT - 1)) begin
                  busy    <= 1'b0;
                  ack     <= 1'b1;
                  state_r <= S_DONE;
               end else begin
                  j_r     <= j_r + JW'(1);
                  state_r <= S_MAC;
               end
            end
            S_DONE: begin
               // Hold the result until the requester lets go, so a stuck-high req cannot retrigger.
               if (!req) begin
                  ack     <= 1'b0;
                  state_r <= S_IDLE;
               end else begin
                  state_r <= S_DONE;
               end
            end
            default: begin
               state_r <= S_IDLE;
               busy    <= 1'b0;
               ack     <= 1'b0;
            end
         endcase
      end
   end

endmodule
